// File: rtl/alu_block_sequencer_pkg.sv
// alu_block_sequencer_pkg: shared opcodes, state encoding and pixel geometry for the ALU block sequencer.
package alu_block_sequencer_pkg;
  localparam int PIX_W = 8;
  localparam int IN_PIX = 4;
  localparam int OUT_PIX = 8;
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_REPL = 4'd1;
  localparam logic [3:0] OP_DECIM = 4'd2;
  localparam logic [3:0] OP_AVG = 4'd3;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_START, S_WRITE, S_RELEASE, S_FINISH} state_t;
  function automatic logic op_ok(input logic [3:0] op);
    return op inside {OP_REPL, OP_DECIM, OP_AVG};
  endfunction
endpackage

// File: rtl/alu_block_sequencer_unpack.sv
// alu_block_sequencer_unpack: holds the 64-bit ALU result and emits it byte by byte with destination addresses.
module alu_block_sequencer_unpack import alu_block_sequencer_pkg::*; #(
  parameter int DST_AW = 19
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       init,
  input  logic                       load,
  input  logic                       step,
  input  logic                       advance,
  input  logic [DST_AW-1:0]          base,
  input  logic [OUT_PIX*PIX_W-1:0]   result,
  output logic [DST_AW-1:0]          wr_addr,
  output logic [PIX_W-1:0]           wr_data,
  output logic                       last
);
  logic [OUT_PIX*PIX_W-1:0] hold;
  logic [2:0] idx;
  logic [DST_AW-1:0] ptr;
  always_ff @(posedge clock) begin
    if (reset) begin
      hold <= '0;
      idx <= '0;
      ptr <= '0;
    end else begin
      if (init) ptr <= base;
      else if (advance) ptr <= ptr + DST_AW'(OUT_PIX);
      if (load) begin
        hold <= result;
        idx <= '0;
      end else if (step) begin
        hold <= hold >> PIX_W;
        idx <= idx + 3'd1;
      end
    end
  end
  // the holding register shifts down, so the current byte is always the low one
  assign wr_addr = ptr + DST_AW'(idx);
  assign wr_data = hold[PIX_W-1:0];
  assign last = idx == 3'(OUT_PIX - 1);
endmodule

// File: rtl/alu_block_sequencer.sv
// alu_block_sequencer: reads 4-pixel blocks, drives the ALU start/done handshake and writes 8-pixel results back.
module alu_block_sequencer import alu_block_sequencer_pkg::*; #(
  parameter int SRC_AW = 17,
  parameter int DST_AW = 19,
  parameter int CNT_W = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [3:0]                cmd_opcode,
  input  logic [SRC_AW-1:0]         cmd_src_base,
  input  logic [DST_AW-1:0]         cmd_dst_base,
  input  logic [CNT_W-1:0]          cmd_blocks,
  output logic [SRC_AW-1:0]         src_rd_addr,
  input  logic [PIX_W-1:0]          src_rd_data,
  output logic                      dst_wr_en,
  output logic [DST_AW-1:0]         dst_wr_addr,
  output logic [PIX_W-1:0]          dst_wr_data,
  output logic [3:0]                alu_opcode,
  output logic                      alu_start,
  output logic [IN_PIX*PIX_W-1:0]   alu_pixels_in,
  input  logic [OUT_PIX*PIX_W-1:0]  alu_pixels_out,
  input  logic                      alu_done,
  output logic                      seq_done,
  output logic                      seq_error
);
  state_t state, state_nx;
  logic [SRC_AW-1:0] src_ptr;
  logic [CNT_W-1:0] remaining;
  logic [3:0] op_q;
  logic err_q;
  logic [2:0] rd_cnt;
  logic [IN_PIX*PIX_W-1:0] pix_q;
  logic last, accept, released;
  assign accept = state == S_IDLE && cmd_valid;
  assign released = state == S_RELEASE && !alu_done;
  always_comb begin
    state_nx = state;
    cmd_ready = state == S_IDLE;
    alu_start = state == S_START || state == S_WRITE;
    dst_wr_en = state == S_WRITE;
    seq_done = state == S_FINISH;
    seq_error = state == S_FINISH && err_q;
    case (state)
      S_IDLE:    if (cmd_valid) state_nx = (!op_ok(cmd_opcode) || cmd_blocks == '0) ? S_FINISH : S_READ;
      S_READ:    if (rd_cnt == 3'(IN_PIX)) state_nx = S_START;
      S_START:   if (alu_done) state_nx = S_WRITE;
      S_WRITE:   if (last) state_nx = S_RELEASE;
      S_RELEASE: if (!alu_done) state_nx = remaining == CNT_W'(1) ? S_FINISH : S_READ;
      S_FINISH:  state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      src_ptr <= '0;
      remaining <= '0;
      op_q <= '0;
      err_q <= 1'b0;
      rd_cnt <= '0;
      pix_q <= '0;
    end else begin
      state <= state_nx;
      rd_cnt <= state == S_READ ? rd_cnt + 3'd1 : 3'd0;
      if (accept) begin
        op_q <= cmd_opcode;
        err_q <= !op_ok(cmd_opcode);
        src_ptr <= cmd_src_base;
        remaining <= cmd_blocks;
      end
      // read data lags the address by a cycle; shifting in from the top leaves pixel 0 in the low byte
      if (state == S_READ && rd_cnt != 3'd0) pix_q <= {src_rd_data, pix_q[IN_PIX*PIX_W-1:PIX_W]};
      if (released) begin
        src_ptr <= src_ptr + SRC_AW'(IN_PIX);
        remaining <= remaining - CNT_W'(1);
      end
    end
  end
  assign src_rd_addr = src_ptr + SRC_AW'(rd_cnt);
  assign alu_pixels_in = pix_q;
  assign alu_opcode = op_q;
  alu_block_sequencer_unpack #(.DST_AW(DST_AW)) u_unpack (
    .clock   (clock),
    .reset   (reset),
    .init    (accept),
    .load    (state == S_START && alu_done),
    .step    (state == S_WRITE),
    .advance (released),
    .base    (cmd_dst_base),
    .result  (alu_pixels_out),
    .wr_addr (dst_wr_addr),
    .wr_data (dst_wr_data),
    .last    (last)
  );
endmodule

// File: tb/tb_alu_block_sequencer.sv
// tb_alu_block_sequencer: scoreboard bench with source memory and ALU models, directed commands.
module tb_alu_block_sequencer;
  localparam int SRC_AW = 17;
  localparam int DST_AW = 19;
  localparam int CNT_W = 16;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [3:0] cmd_opcode = '0;
  logic [SRC_AW-1:0] cmd_src_base = '0;
  logic [DST_AW-1:0] cmd_dst_base = '0;
  logic [CNT_W-1:0] cmd_blocks = '0;
  logic [SRC_AW-1:0] src_rd_addr;
  logic [7:0] src_rd_data = '0;
  logic dst_wr_en;
  logic [DST_AW-1:0] dst_wr_addr;
  logic [7:0] dst_wr_data;
  logic [3:0] alu_opcode;
  logic alu_start;
  logic [31:0] alu_pixels_in;
  logic [63:0] alu_pixels_out = '0;
  logic alu_done = 1'b0;
  logic seq_done, seq_error;

  always #5 clock = ~clock;

  alu_block_sequencer #(.SRC_AW(SRC_AW), .DST_AW(DST_AW), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_src_base(cmd_src_base), .cmd_dst_base(cmd_dst_base),
    .cmd_blocks(cmd_blocks), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data),
    .alu_opcode(alu_opcode), .alu_start(alu_start), .alu_pixels_in(alu_pixels_in),
    .alu_pixels_out(alu_pixels_out), .alu_done(alu_done), .seq_done(seq_done), .seq_error(seq_error)
  );

  logic [7:0] smem [256];
  initial for (int i = 0; i < 256; i++) smem[i] = 8'(i * 17 + 17);
  always @(posedge clock) src_rd_data <= smem[src_rd_addr[7:0]];

  function automatic logic [63:0] alu_f(input logic [31:0] px);
    return {px + 32'h44444444, px};
  endfunction

  int alu_delay = 1;
  int alu_cnt = 0;
  always @(posedge clock) begin
    if (reset || !alu_start) begin
      alu_cnt <= 0;
      alu_done <= 1'b0;
    end else begin
      alu_cnt <= alu_cnt + 1;
      if (alu_cnt + 1 >= alu_delay) alu_done <= 1'b1;
      alu_pixels_out <= alu_f(alu_pixels_in);
    end
  end

  logic [26:0] wr_q[$];
  logic [35:0] px_q[$];
  logic [31:0] done_q[$];
  int total = 0, bad = 0;
  int cyc = 0, acc_cyc = 0, done_cyc = 0, n_wr = 0, n_start = 0;
  logic prev_start = 1'b0, prev_done = 1'b0, prev_wr = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    total++;
    bad++;
    $display("FAIL unexpected %s at cycle %0d", nm, cyc);
  endtask

  always @(negedge clock) begin
    logic [35:0] p;
    logic [26:0] w;
    logic [31:0] d;
    cyc++;
    if (!reset) begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (alu_done && !prev_done) done_cyc = cyc;
      if (alu_start && !prev_start) begin
        n_start++;
        if (px_q.size() == 0) unexp("alu_start");
        else begin
          p = px_q.pop_front();
          chk("alu_pixels_in", alu_pixels_in, p[31:0]);
          chk("alu_opcode", alu_opcode, p[35:32]);
        end
      end
      if (dst_wr_en) begin
        n_wr++;
        if (!prev_wr) chk("write_after_done", cyc - done_cyc, 1);
        if (wr_q.size() == 0) unexp("dst_wr_en");
        else begin
          w = wr_q.pop_front();
          chk("dst_wr_addr", dst_wr_addr, w[26:8]);
          chk("dst_wr_data", dst_wr_data, w[7:0]);
        end
      end
      if (seq_done) begin
        if (done_q.size() == 0) unexp("seq_done");
        else begin
          d = done_q.pop_front();
          chk("seq_error", seq_error, d[31]);
          chk("latency", cyc - acc_cyc + 1, d[30:0]);
        end
      end
    end
    prev_start = alu_start;
    prev_done = alu_done;
    prev_wr = dst_wr_en;
  end

  task automatic push_cmd(input logic [3:0] op, input logic [SRC_AW-1:0] src,
                          input logic [DST_AW-1:0] dst, input int n, input int lat);
    logic [SRC_AW-1:0] a;
    logic [DST_AW-1:0] da;
    logic [31:0] px;
    logic [63:0] o;
    if (op inside {4'd1, 4'd2, 4'd3})
      for (int b = 0; b < n; b++) begin
        for (int k = 0; k < 4; k++) begin
          a = src + SRC_AW'(4 * b + k);
          px[8*k +: 8] = smem[a[7:0]];
        end
        px_q.push_back({op, px});
        o = alu_f(px);
        for (int k = 0; k < 8; k++) begin
          da = dst + DST_AW'(8 * b + k);
          wr_q.push_back({da, o[8*k +: 8]});
        end
      end
    done_q.push_back({!(op inside {4'd1, 4'd2, 4'd3}), 31'(lat)});
  endtask

  task automatic drive(input logic [3:0] op, input logic [SRC_AW-1:0] src,
                       input logic [DST_AW-1:0] dst, input logic [CNT_W-1:0] n);
    @(posedge clock);
    #1;
    cmd_opcode = op;
    cmd_src_base = src;
    cmd_dst_base = dst;
    cmd_blocks = n;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [SRC_AW-1:0] src,
                       input logic [DST_AW-1:0] dst, input int n, input int lat);
    push_cmd(op, src, dst, n, lat);
    drive(op, src, dst, CNT_W'(n));
  endtask

  task automatic wait_idle(input string nm);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(posedge clock);
      if (done_q.size() == 0 && wr_q.size() == 0 && px_q.size() == 0) break;
    end
    if (i == 3000) begin
      total++;
      bad++;
      $display("FAIL timeout %s: wr_left=%0d done_left=%0d", nm, wr_q.size(), done_q.size());
      wr_q.delete();
      px_q.delete();
      done_q.delete();
    end
    repeat (3) @(posedge clock);
  endtask

  initial begin
    int w0, s0, i;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_dst_wr_en", dst_wr_en, 0);
    chk("rst_seq_done", seq_done, 0);
    chk("rst_seq_error", seq_error, 0);
    chk("rst_src_rd_addr", src_rd_addr, 0);
    chk("rst_dst_wr_addr", dst_wr_addr, 0);
    chk("rst_dst_wr_data", dst_wr_data, 0);
    chk("rst_alu_pixels_in", alu_pixels_in, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    issue(4'd1, '0, 19'h100, 1, 19);
    wait_idle("single");
    chk("pixels_in_hold", alu_pixels_in, 32'h44332211);

    s0 = n_start;
    issue(4'd3, '0, 19'h200, 3, 53);
    wait_idle("three_blocks");
    chk("three_starts", n_start - s0, 3);

    w0 = n_wr;
    s0 = n_start;
    issue(4'd0, 17'h10, 19'h300, 1, 2);
    wait_idle("op0");
    issue(4'd7, 17'h10, 19'h300, 1, 2);
    wait_idle("op7");
    issue(4'd2, 17'h10, 19'h300, 0, 2);
    wait_idle("blocks0");
    chk("no_writes", n_wr - w0, 0);
    chk("no_starts", n_start - s0, 0);

    alu_delay = 5;
    issue(4'd2, 17'h4, 19'h300, 1, 23);
    repeat (6) @(posedge clock);
    #1;
    chk("busy_cmd_ready", cmd_ready, 0);
    cmd_opcode = 4'd1;
    cmd_blocks = 16'd5;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    wait_idle("slow_alu");
    alu_delay = 1;

    push_cmd(4'd1, 17'h8, 19'h500, 1, 0);
    drive(4'd1, 17'h8, 19'h500, 16'd1);
    for (i = 0; i < 100; i++) begin
      @(negedge clock);
      if (dst_wr_en && dst_wr_addr == 19'h503) break;
    end
    if (i == 100) unexp("missing write cycle 3");
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("midrst_dst_wr_en", dst_wr_en, 0);
    chk("midrst_alu_start", alu_start, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    reset = 1'b0;
    chk("midrst_writes_left", wr_q.size(), 4);
    chk("midrst_done_left", done_q.size(), 1);
    wr_q.delete();
    px_q.delete();
    done_q.delete();
    repeat (2) @(posedge clock);
    issue(4'd1, 17'h8, 19'h500, 2, 36);
    wait_idle("after_reset");

    issue(4'd1, 17'h1FFFE, 19'h7FFFC, 1, 19);
    wait_idle("wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
